pe_tile_sequencer: RTL

- Initiator and feeder for the bit-plane processing element (PE). Drives the PE's start/tile inputs and consumes its done/result outputs.
- Accepts a streamed 4-bit weight matrix and an 8-bit activation matrix, one element pair per beat.
- Decomposes weights into bit planes, issues one PE operation per tile, captures the result tile, re-arms the PE, and streams the results out with valid/ready.

---
 rtl/pe_tile_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pe_tile_sequencer.sv
// pe_tile_sequencer: streams in a weight/activation tile, runs the bit-plane PE once, streams out the result tile.
// Defining PE_TIMEOUT_EN adds a watchdog on the PE handshake and drives err_timeout.
module pe_tile_sequencer #(
    parameter int TILE_SIZE      = 4,
    parameter int ACT_WIDTH      = 8,
    parameter int NUM_BIT_PLANES = 4,
    parameter int RESULT_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [NUM_BIT_PLANES-1:0]                     in_weight,
    input  logic [ACT_WIDTH-1:0]                          in_act,
    output logic                                          pe_start,
    input  logic                                          pe_done,
    output logic                                          pe_rst_n,
    output logic [NUM_BIT_PLANES*TILE_SIZE*TILE_SIZE-1:0] pe_weight_tiles,
    output logic [ACT_WIDTH*TILE_SIZE*TILE_SIZE-1:0]      pe_activation_tile,
    input  logic [RESULT_WIDTH*TILE_SIZE*TILE_SIZE-1:0]   pe_result_tile,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [RESULT_WIDTH-1:0]                       out_data,
    output logic                                          out_last,
    output logic                                          busy,
    output logic [15:0]                                   tile_count,
    output logic                                          err_timeout
);
    localparam int TT = TILE_SIZE * TILE_SIZE;
    localparam int CW = (TT > 1) ? $clog2(TT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TT - 1);

    typedef enum logic [2:0] {LOAD, ISSUE, WAIT, CAPTURE, REARM, DRAIN} state_t;

    state_t                       state_q;
    logic [CW-1:0]                n_q, m_q;
    logic                         in_ready_q, pe_start_q, out_valid_q;
    logic [15:0]                  tile_count_q;
    logic [NUM_BIT_PLANES*TT-1:0] w_q;
    logic [ACT_WIDTH*TT-1:0]      a_q;
    logic [RESULT_WIDTH*TT-1:0]   r_q;
    logic                         load_fire, drain_fire;

`ifdef PE_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q;
    logic          err_q;
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    assign load_fire          = in_valid && in_ready_q;
    assign drain_fire         = out_valid_q && out_ready;
    assign in_ready           = in_ready_q;
    assign pe_start           = pe_start_q;
    assign out_valid          = out_valid_q;
    assign out_last           = out_valid_q && (m_q == LAST);
    assign out_data           = r_q[int'(m_q)*RESULT_WIDTH +: RESULT_WIDTH];
    assign busy               = (state_q != LOAD);
    assign tile_count         = tile_count_q;
    assign pe_rst_n           = rst_n && (state_q != REARM);
    assign pe_weight_tiles    = w_q;
    assign pe_activation_tile = a_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            n_q          <= '0;
            m_q          <= '0;
            in_ready_q   <= 1'b0;
            pe_start_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            tile_count_q <= '0;
            w_q          <= '0;
            a_q          <= '0;
            r_q          <= '0;
`ifdef PE_TIMEOUT_EN
            wd_q         <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    in_ready_q <= !(load_fire && n_q == LAST);
                    if (load_fire) begin
                        // weight bit b of element e lands in plane b at the same element position
                        for (int e = 0; e < TT; e++) begin
                            if (n_q == CW'(e)) begin
                                for (int b = 0; b < NUM_BIT_PLANES; b++) w_q[b*TT + e] <= in_weight[b];
                                a_q[e*ACT_WIDTH +: ACT_WIDTH] <= in_act;
                            end
                        end
                        n_q <= (n_q == LAST) ? '0 : n_q + 1'b1;
                        if (n_q == LAST) begin
                            state_q    <= ISSUE;
                            pe_start_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    pe_start_q <= 1'b0;
                    state_q    <= WAIT;
`ifdef PE_TIMEOUT_EN
                    wd_q       <= '0;
`endif
                end
                WAIT: begin
                    if (pe_done) state_q <= CAPTURE;
`ifdef PE_TIMEOUT_EN
                    else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                        err_q   <= 1'b1;
                        r_q     <= '0;
                        state_q <= REARM;
                    end else wd_q <= wd_q + 1'b1;
`endif
                end
                CAPTURE: begin
                    r_q     <= pe_result_tile;
                    state_q <= REARM;
                end
                REARM: begin
                    out_valid_q <= 1'b1;
                    state_q     <= DRAIN;
                end
                DRAIN: begin
                    if (drain_fire) begin
                        if (m_q == LAST) begin
                            m_q          <= '0;
                            out_valid_q  <= 1'b0;
                            in_ready_q   <= 1'b1;
                            tile_count_q <= tile_count_q + 1'b1;
                            state_q      <= LOAD;
                        end else m_q <= m_q + 1'b1;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end
endmodule
